// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: streams a fixed-length message through an alphabet-shift cipher with a cyclic key.
// Optional CIPHER_PASSTHRU_EN: invalid characters pass through instead of aborting the message.
module cipher_stream_ctrl #(
    parameter int MSG_LEN = 6,
    parameter int SEC_LEN = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_key_load,
    input  logic [8*SEC_LEN-1:0]         i_key_in,
    input  logic                         i_start,
    input  logic                         i_mode,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [7:0]                   i_in_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [7:0]                   o_out_data,
    output logic                         o_out_last,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err,
    output logic [$clog2(MSG_LEN+1)-1:0] o_err_pos
);
    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int IW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MSG_LEN - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SEC_LEN - 1);
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_Z  = 8'h5A;
    localparam logic [7:0] ALPHA = 8'd26;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [8*SEC_LEN-1:0] r_key;
    logic [IW-1:0]        r_idx;
    logic [CW-1:0]        r_cnt;
    logic                 r_mode;
    logic                 r_outValid;
    logic [7:0]           r_outData;
    logic                 r_outLast;
    logic                 r_done;
    logic                 r_err;
    logic [CW-1:0]        r_errPos;

    logic [7:0] w_keyByte;
    logic [7:0] w_pos;
    logic [7:0] w_kVal;
    logic [7:0] w_sum;
    logic [7:0] w_cipher;
    logic       w_invalid;
    logic       w_outFree;
    logic       w_inReady;
    logic       w_accept;
    logic       w_isLast;
    logic       w_emit;
    logic       w_finish;

    always_comb begin
        w_keyByte = 8'h00;
        for (int i = 0; i < SEC_LEN; i++) begin
            if (r_idx == IW'(i)) w_keyByte = r_key[8*i +: 8];
        end
    end

    // Both directions stay within 6 bits before the single conditional wrap by 26.
    assign w_invalid = (i_in_data < CH_A) || (i_in_data > CH_Z);
    assign w_pos     = w_invalid ? 8'hFF : (i_in_data - CH_A);
    assign w_kVal    = w_keyByte - CH_A;
    assign w_sum     = r_mode ? (w_pos + ALPHA - w_kVal) : (w_pos + w_kVal);
    assign w_cipher  = ((w_sum >= ALPHA) ? (w_sum - ALPHA) : w_sum) + CH_A;

    assign w_outFree = !r_outValid || i_out_ready;
    assign w_inReady = ((r_state == RUN) && w_outFree) || (r_state == DRAIN);
    assign w_accept  = i_in_valid && w_inReady;
    assign w_isLast  = (r_cnt == LAST_CNT);
`ifdef CIPHER_PASSTHRU_EN
    assign w_emit = w_accept && (r_state == RUN);
`else
    assign w_emit = w_accept && (r_state == RUN) && !w_invalid;
`endif

    // An accept in RUN implies the output slot is free, so an invalid final byte can finish directly.
    always_comb begin
        w_nextState = r_state;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_nextState = RUN;
            end
            RUN: begin
                if (w_accept) begin
                    if (w_emit) begin
                        if (w_isLast) w_nextState = FLUSH;
                    end else if (w_isLast) begin
                        w_nextState = IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_nextState = DRAIN;
                    end
                end
            end
            FLUSH: begin
                if (w_outFree) begin
                    w_nextState = IDLE;
                    w_finish    = 1'b1;
                end
            end
            DRAIN: begin
                if (w_accept && w_isLast) begin
                    if (w_outFree) begin
                        w_nextState = IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_nextState = FLUSH;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_key      <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= 8'h00;
            r_outLast  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errPos   <= '0;
        end else begin
            r_state <= w_nextState;
            r_done  <= w_finish;
            if (r_state == IDLE) begin
                if (i_key_load) r_key <= i_key_in;
                if (i_start) begin
                    r_mode   <= i_mode;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    r_err    <= 1'b0;
                    r_errPos <= '0;
                end
            end
            if (w_accept) r_cnt <= r_cnt + 1'b1;
            if (w_accept && (r_state == RUN) && !w_invalid) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : (r_idx + 1'b1);
            end
            if (w_accept && (r_state == RUN) && w_invalid && !r_err) begin
                r_err    <= 1'b1;
                r_errPos <= r_cnt;
            end
            if (w_emit) begin
                r_outValid <= 1'b1;
                r_outData  <= w_invalid ? i_in_data : w_cipher;
                r_outLast  <= w_isLast;
            end else if (i_out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_inReady;
    assign o_out_valid = r_outValid;
    assign o_out_data  = r_outData;
    assign o_out_last  = r_outLast;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_pos   = r_errPos;

endmodule

// File: doc/cipher_stream_ctrl.md
# cipher_stream_ctrl

Sequencing controller for the character cipher datapath. Accepts a message of MSG_LEN bytes over a valid/ready stream, steps a SEC_LEN-byte secret key cyclically across it, and applies the alphabet-shift encrypt or decrypt per byte. Invalid characters, whose alphabet lookup yields 8'hFF, are either passed through or abort the message. Encryptor and decryptor test benches drive and check messages through this block.

## Interface
- MSG_LEN, 6, bytes per message (≥1)
- SEC_LEN, 7, key length in bytes (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_load  in  1  load key_in into the key register; honoured only in IDLE
- key_in  in  8*SEC_LEN  key bytes, byte 0 in bits [7:0]; each must be 'A'..'Z'
- start  in  1  begin a message; honoured only in IDLE
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on accepted start
- in_valid / in_ready  in / out  1  input byte handshake
- in_data  in  8  input character
- out_valid / out_ready  out / in  1  output byte handshake
- out_data  out  8  output character
- out_last  out  1  marks the final output byte of a message
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a message completes, with or without error
- err  out  1  sticky invalid-character flag; cleared on the next accepted start
- err_pos  out  $clog2(MSG_LEN+1)  index of the first invalid byte

## Operation
- Alphabet is 'A'..'Z'. Position p = in_data − 'A' when valid, else 8'hFF (invalid). Key value k = key[idx] − 'A'.
- Encrypt: c = p + k; if c ≥ 26 then c −= 26 (6-bit sum). Decrypt: c = p + 26 − k, reduced the same way. Output = c + 'A'.
- Key index idx resets to 0 on each accepted start. It advances only on a valid character and wraps from SEC_LEN−1 to 0. The byte counter cnt counts every accepted byte.
- FSM states:
  - IDLE: on start, go to RUN, clear cnt, idx and err.
  - RUN: accept bytes. When byte MSG_LEN−1 is accepted, go to FLUSH.
  - FLUSH: wait until the last output is taken, pulse done, go to IDLE.
  - DRAIN: accept and discard remaining bytes until cnt reaches MSG_LEN, pulse done, go to IDLE. This keeps the upstream stream aligned.
- Invalid byte in RUN: behaviour depends on the configuration macro.
- key_load or start while busy: ignored. Simultaneous key_load and start in IDLE: the key is loaded and the message uses the new key.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0, err 0, err_pos 0, key register 0. State IDLE.
- in_ready = (state==RUN && (!out_valid || out_ready)) || state==DRAIN.
- Latency: a byte accepted in cycle n appears on out_data in cycle n+1 from a single output register. Throughput is 1 byte/cycle when out_ready stays high.
- While out_valid && !out_ready: out_data and out_last hold stable, and in_ready is 0 in RUN.
- done asserts on the cycle after the final handshake, output or drain.
- rst_n asserted mid-message: everything clears immediately. The partial message is lost and no done pulse is produced.

## Configuration
- CIPHER_PASSTHRU_EN defined: an invalid byte is emitted unchanged, idx does not advance, err and err_pos are still recorded for the first occurrence, and the message completes normally.
- Not defined: the first invalid byte produces no output, sets err and err_pos, and moves the FSM to DRAIN. An output still pending is delivered first; its out_last is 0.

## Test plan
- Key "BBBBBBB", encrypt "HELLOZ" → "IFMMPA", out_last on 'A', done 1 cycle later, err=0. Decrypt "IFMMPA" → "HELLOZ".
- Key wrap with MSG_LEN=9, key "ABCDEFG", encrypt "AAAAAAAAA" → "ABCDEFGAB".
- Backpressure: key "BBBBBBB", "HELLOZ", out_ready low for 5 cycles after the first byte → out_data holds 'I', in_ready=0, and the full sequence arrives intact.
- Macro defined: key "BCDEFGH", encrypt "A@B$CD" → "B@D$FH", err=1, err_pos=1.
- Macro undefined: "@#$%^&" → no output bytes, err=1, err_pos=0, all 6 bytes consumed, done pulses, then IDLE.
- rst_n low after 3 bytes of "HELLOZ" → all outputs at reset values. A new message then encrypts correctly with idx restarting at 0.
